neuron_mac_q48: RTL and testbench
=================================

# neuron_mac_q48

Serial multiply-accumulate neuron that produces the 12-bit two's-complement Q4.8 pre-activation `x` consumed by the downstream `sigmoid_taylor` stage. It accepts (activation, weight) pairs over a valid/ready stream, adds a bias, then rounds and saturates to Q4.8. It holds the result on a valid/ready output until the consumer accepts it.

## Interface
- `N_INPUTS`, 8: maximum beats per vector (1..255).
- `ACC_W`, 28: accumulator width, signed Q12.16 at default.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset (fixed decision: one clock; reset asynchronous, active-high).
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_last` in 1: marks the final beat of a vector.
- `in_a` in 12: activation, signed Q4.8.
- `in_w` in 12: weight, signed Q4.8.
- `bias` in 12: signed Q4.8; sampled on the first beat of each vector.
- `x` out 12: saturated signed Q4.8 result; drives `sigmoid_taylor.x`.
- `x_valid` out 1: `x` holds a new result.
- `x_ready` in 1: consumer accepts `x`.
- `ovf` out 1: the current result was saturated; valid with `x_valid`.
- `len_err` out 1: the vector was terminated by `N_INPUTS` with no `in_last`; valid with `x_valid`.

## Operation
- States: IDLE, ACC, DRAIN, OUT. `in_ready` = state is IDLE or ACC (registered-state decode).
- Beat accept: `in_valid && in_ready`.
- IDLE:
  - On accept, load acc with `sext(bias) << 8`, register the product, and set count = 1.
  - If last, go to DRAIN; otherwise go to ACC.
- ACC:
  - Each accept registers the product and increments count.
  - The previous product is added to acc every cycle its product-valid bit is set.
  - The vector ends on `in_last`, or when count reaches `N_INPUTS`; then go to DRAIN.
- Product: full 24-bit signed Q8.16, sign-extended to `ACC_W`. The accumulator wraps modulo 2^ACC_W; no internal saturation.
- DRAIN: one cycle to add the final product. On exit, register `x` = sat(round(acc >> 8)) and set `ovf`/`len_err`; go to OUT.
- Saturation bounds: `0x7FF` (+7.996) and `0x800` (-8.0). `ovf` = 1 when a clamp occurred.
- OUT:
  - `x`, `ovf` and `len_err` are held stable while `x_valid` = 1.
  - On `x_valid && x_ready`, drop `x_valid` and go to IDLE.
- Input is never accepted in DRAIN or OUT.
- `len_err`: set when the end was forced by count == `N_INPUTS` with `in_last` = 0. If `in_last` arrives exactly on beat `N_INPUTS`, `len_err` = 0.
- `in_valid` low during ACC: the block waits indefinitely, and acc keeps the pending product add.

## Timing
- Reset values: `x` = 0, `x_valid` = 0, `ovf` = 0, `len_err` = 0, state IDLE (`in_ready` = 1 once `rst` deasserts), acc and count = 0.
- `rst` asserted mid-vector or mid-OUT clears everything immediately. The partial vector is discarded and no result is produced.
- Latency: last beat accepted at edge k gives the final acc at edge k+1 and `x`/`x_valid` registered at edge k+2.
- Handshake to IDLE: `x_valid && x_ready` at edge m gives `in_ready` = 1 after edge m. The earliest next accept is edge m+1.
- Throughput: one beat per cycle within a vector. Between vectors, at least 3 cycles of `in_ready` = 0 (DRAIN plus OUT).
- `sigmoid_taylor` registers `f_x` one cycle after sampling `x`. `x` is stable from `x_valid` rise until the handshake.

## Configuration
- `NEURON_MAC_ROUND_EN` defined: round half up, i.e. add `1 << 7` before the arithmetic shift right by 8.
- `NEURON_MAC_ROUND_EN` undefined: truncate toward -inf (plain arithmetic shift).
- Saturation and `ovf` behave identically in both builds.

## Structure
- Package `neuron_pkg` holds:
  - typedef `q48_t` (logic signed [11:0]);
  - `FRAC_BITS = 8`, `Q48_MAX = 12'h7FF`, `Q48_MIN = 12'h800`;
  - state enum `mac_state_t` {IDLE, ACC, DRAIN, OUT}.
- Sub-module `sat_round_q48`: combinational; inputs acc (`ACC_W`); outputs `q48_t` and `ovf`. It contains the `NEURON_MAC_ROUND_EN` switch.
- Top level holds the FSM, beat counter, product register and accumulator.

## Test plan
- Single beat, `a=0x100`, `w=0x200`, `bias=0`, `last=1` -> `x=0x200`, `ovf=0`, `x_valid` rises 2 edges after acceptance.
- Bias only, `a=0`, `w=0`, `bias=0xF00`, `last=1` -> `x=0xF00`.
- Saturation:
  - 4 beats `a=0x700`, `w=0x700` -> `x=0x7FF`, `ovf=1`.
  - 4 beats `a=0x700`, `w=0x900` -> `x=0x800`, `ovf=1`.
- Rounding, `a=0x001`, `w=0x080`, `bias=0`:
  - with `NEURON_MAC_ROUND_EN` -> `x=0x001`;
  - without -> `x=0x000`.
- Backpressure: hold `x_ready=0` for 10 cycles -> `x` stable and `in_ready=0` throughout; release for 1 cycle -> exactly one handshake, `in_ready=1` the next cycle.
- Length and reset:
  - 8 beats with no `in_last` (`N_INPUTS=8`) -> result after the 8th beat, `len_err=1`.
  - Assert `rst` after beat 3 of the next vector -> `x_valid=0` and `x=0` immediately. A following 1-beat vector `a=0x100`, `w=0x100` -> `x=0x100`.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and constants for the Q4.8 multiply-accumulate neuron.
//   q48_t        - signed Q4.8 value (12 bits)
//   FRAC_BITS    - fractional bits of Q4.8
//   Q48_MAX/MIN  - saturation bounds (+7.996 / -8.0)
//   mac_state_t  - MAC controller states
package neuron_pkg;

    typedef logic signed [11:0] q48_t;

    localparam int unsigned FRAC_BITS = 8;
    localparam q48_t        Q48_MAX   = 12'sh7FF;
    localparam q48_t        Q48_MIN   = 12'sh800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } mac_state_t;

endpackage

// File: rtl/neuron_mac_q48_if.sv
// neuron_mac_q48_if: input beat stream and result stream of the MAC neuron.
//   Input stream : in_valid, in_ready, in_last, in_a, in_w, bias
//   Result stream: x, x_valid, x_ready, ovf, len_err
//   modport master - producer of beats / consumer of results (testbench, upstream)
//   modport slave  - the neuron itself
interface neuron_mac_q48_if;
    import neuron_pkg::*;

    logic in_valid;
    logic in_ready;
    logic in_last;
    q48_t in_a;
    q48_t in_w;
    q48_t bias;
    q48_t x;
    logic x_valid;
    logic x_ready;
    logic ovf;
    logic len_err;

    modport master (
        output in_valid, in_last, in_a, in_w, bias, x_ready,
        input  in_ready, x, x_valid, ovf, len_err
    );

    modport slave (
        input  in_valid, in_last, in_a, in_w, bias, x_ready,
        output in_ready, x, x_valid, ovf, len_err
    );

endinterface

// File: rtl/sat_round_q48.sv
// sat_round_q48: combinational conversion of a signed Q(ACC_W-16).16 accumulator to Q4.8.
//   acc - signed accumulator (ACC_W bits, 16 fractional bits)
//   x   - rounded/truncated and saturated Q4.8 result
//   ovf - high when the result was clamped to Q48_MAX or Q48_MIN
// Build option NEURON_MAC_ROUND_EN: defined -> round half up (add 1<<7 before the shift);
// undefined -> truncate toward -inf.
module sat_round_q48
    import neuron_pkg::*;
#(
    parameter int unsigned ACC_W = 28
) (
    input  logic signed [ACC_W-1:0] acc,
    output q48_t                    x,
    output logic                    ovf
);

    localparam int unsigned SW = ACC_W + 1 - FRAC_BITS;

    // One extra bit so the rounding increment can never wrap.
    logic signed [ACC_W:0] biased;
    logic signed [SW-1:0]  shr;
    logic [SW-12:0]        hi;
    logic                  unused_frac;

    always_comb begin
`ifdef NEURON_MAC_ROUND_EN
        biased = {acc[ACC_W-1], acc} + (ACC_W + 1)'(1 << (FRAC_BITS - 1));
`else
        biased = {acc[ACC_W-1], acc};
`endif
        shr = biased[ACC_W:FRAC_BITS];
        // Fits in 12 bits only if every bit above bit 11 equals the sign bit.
        hi  = shr[SW-1:11];
        ovf = !((&hi) || (~|hi));
        if (!ovf) begin
            x = shr[11:0];
        end else if (shr[SW-1]) begin
            x = Q48_MIN;
        end else begin
            x = Q48_MAX;
        end
    end

    assign unused_frac = ^biased[FRAC_BITS-1:0];

endmodule

// File: rtl/neuron_mac_q48.sv
// neuron_mac_q48: serial multiply-accumulate neuron producing a saturated Q4.8 pre-activation.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - neuron_mac_q48_if.slave: (a, w) beat stream with bias and in_last in,
//          result x with ovf/len_err out on a valid/ready handshake
// Parameters: N_INPUTS (max beats per vector, 1..255), ACC_W (accumulator width).
// Build option NEURON_MAC_ROUND_EN selects rounding in sat_round_q48.
module neuron_mac_q48
    import neuron_pkg::*;
#(
    parameter int unsigned N_INPUTS = 8,
    parameter int unsigned ACC_W    = 28
) (
    input logic              clk,
    input logic              rst,
    neuron_mac_q48_if.slave  bus
);

    mac_state_t               state_q;
    logic [7:0]               count_q;
    logic signed [23:0]       prod_q;
    logic                     prod_vld_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     len_pend_q;
    q48_t                     x_q;
    logic                     x_valid_q;
    logic                     ovf_q;
    logic                     len_err_q;

    logic                     in_ready;
    logic                     accept;
    logic signed [23:0]       prod_mul;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_add;
    logic [7:0]               cnt_next;
    logic                     cnt_hit;
    logic                     vec_end;
    q48_t                     sat_x;
    logic                     sat_ovf;

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == ACC);
        accept   = bus.in_valid && in_ready;
        prod_mul = bus.in_a * bus.in_w;
        prod_ext = {{(ACC_W - 24){prod_q[23]}}, prod_q};
        bias_ext = {{(ACC_W - 20){bus.bias[11]}}, bus.bias, 8'h00};
        acc_add  = acc_q + (prod_vld_q ? prod_ext : '0);
        cnt_next = (state_q == IDLE) ? 8'd1 : count_q + 8'd1;
        cnt_hit  = (cnt_next == 8'(N_INPUTS));
        vec_end  = bus.in_last || cnt_hit;
    end

    sat_round_q48 #(
        .ACC_W (ACC_W)
    ) u_sat (
        .acc (acc_q),
        .x   (sat_x),
        .ovf (sat_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            len_pend_q <= 1'b0;
            x_q        <= '0;
            x_valid_q  <= 1'b0;
            ovf_q      <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q      <= bias_ext;
                        prod_q     <= prod_mul;
                        prod_vld_q <= 1'b1;
                        count_q    <= cnt_next;
                        len_pend_q <= cnt_hit && !bus.in_last;
                        state_q    <= vec_end ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    acc_q <= acc_add;
                    if (accept) begin
                        prod_q     <= prod_mul;
                        prod_vld_q <= 1'b1;
                        count_q    <= cnt_next;
                        if (vec_end) begin
                            len_pend_q <= !bus.in_last;
                            state_q    <= DRAIN;
                        end
                    end else begin
                        // Pending product has just been folded in; nothing new to add.
                        prod_vld_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle folds in the last product, second registers x.
                    if (prod_vld_q) begin
                        acc_q      <= acc_add;
                        prod_vld_q <= 1'b0;
                    end else begin
                        x_q       <= sat_x;
                        ovf_q     <= sat_ovf;
                        len_err_q <= len_pend_q;
                        x_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (bus.x_ready) begin
                        x_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.x        = x_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.ovf      = ovf_q;
    assign bus.len_err  = len_err_q;

endmodule

// File: tb/tb_neuron_mac_q48.sv
// tb_neuron_mac_q48: self-checking bench for neuron_mac_q48 (N_INPUTS=8, ACC_W=28).
// Expected results are pushed to a scoreboard queue when a vector is driven and popped
// when the DUT presents x_valid. Inputs are driven and outputs sampled on the falling edge.
module tb_neuron_mac_q48;
    import neuron_pkg::*;

    typedef struct packed {
        logic [11:0] x;
        logic        ovf;
        logic        len_err;
    } exp_t;

    typedef logic [11:0] vec_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;

    neuron_mac_q48_if bus ();

    neuron_mac_q48 #(
        .N_INPUTS (8),
        .ACC_W    (28)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Independent reference: exact integer arithmetic, then wrap, round/shift, clamp.
    function automatic exp_t model(input logic [11:0] b, input vec_t av, input vec_t wv,
                                   input int n, input bit forced);
        longint acc;
        exp_t   r;
        acc = longint'($signed(b)) * 256;
        for (int i = 0; i < n; i++) begin
            acc += longint'($signed(av[i])) * longint'($signed(wv[i]));
        end
        acc = (acc <<< 36) >>> 36;
`ifdef NEURON_MAC_ROUND_EN
        acc += 128;
`endif
        acc = acc >>> 8;
        r.ovf = 1'b0;
        if (acc > 2047) begin
            r.x   = 12'h7FF;
            r.ovf = 1'b1;
        end else if (acc < -2048) begin
            r.x   = 12'h800;
            r.ovf = 1'b1;
        end else begin
            r.x = acc[11:0];
        end
        r.len_err = forced;
        return r;
    endfunction

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Present one beat and return on the falling edge after it was accepted.
    task automatic send_beat(input logic [11:0] a, input logic [11:0] w, input logic [11:0] b,
                             input logic last, output bit timed_out);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_w     = w;
        bus.bias     = b;
        bus.in_last  = last;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        timed_out = !bus.in_ready;
        @(negedge clk);
    endtask

    task automatic send_vec(input vec_t av, input vec_t wv, input logic [11:0] b, input int n,
                            input bit last_on_end, output bit timed_out);
        bit to;
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_beat(av[i], wv[i], b, last_on_end && (i == n - 1), to);
            timed_out |= to;
        end
        idle_in();
    endtask

    // Wait (bounded) for x_valid and fetch observed and expected results.
    task automatic collect(output bit ok, output exp_t got, output exp_t want);
        int cyc = 0;
        while (!bus.x_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        ok   = bus.x_valid && (sb.size() > 0);
        got  = {bus.x, bus.ovf, bus.len_err};
        want = (sb.size() > 0) ? sb.pop_front() : '0;
    endtask

    task automatic handshake();
        bus.x_ready = 1'b1;
        @(negedge clk);
        bus.x_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.x_ready = 1'b0;
        idle_in();
        bus.in_a = '0;
        bus.in_w = '0;
        bus.bias = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.x !== 12'h000 || bus.x_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_x: x=%h x_valid=%b, want 000/0", bus.x, bus.x_valid);
        end
        n_cmp++;
        if (bus.ovf !== 1'b0 || bus.len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ovf=%b len_err=%b, want 0/0", bus.ovf, bus.len_err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        bit to, ok;
        exp_t got, want;
        sb.push_back({12'h200, 1'b0, 1'b0});
        send_beat(12'h100, 12'h200, 12'h000, 1'b1, to);
        idle_in();
        @(negedge clk);
        n_cmp++;
        if (to || bus.x_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_lat_early: x_valid=%b timeout=%b, want 0/0", bus.x_valid, to);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.x_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_lat_k2: x_valid=%b want 1", bus.x_valid);
        end
        collect(ok, got, want);
        n_cmp++;
        if (!ok || got !== want) begin
            n_fail++;
            $display("FAIL single_result: got %h ok=%b want %h", got, ok, want);
        end
        handshake();
    endtask

    task automatic test_vector(input string name, input logic [11:0] a, input logic [11:0] w,
                               input logic [11:0] b, input int n, input exp_t exp_r);
        bit to, ok;
        exp_t got, want;
        vec_t av, wv;
        for (int i = 0; i < 8; i++) begin
            av[i] = a;
            wv[i] = w;
        end
        sb.push_back(exp_r);
        send_vec(av, wv, b, n, 1'b1, to);
        collect(ok, got, want);
        n_cmp++;
        if (to || !ok || got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h ok=%b to=%b want %h", name, got, ok, to, want);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        bit to, ok, stable;
        exp_t got, want;
        sb.push_back({12'h300, 1'b0, 1'b0});
        send_beat(12'h100, 12'h300, 12'h000, 1'b1, to);
        idle_in();
        bus.in_valid = 1'b1;    // offered beat must not be taken while the result waits
        collect(ok, got, want);
        n_cmp++;
        if (to || !ok || got !== want) begin
            n_fail++;
            $display("FAIL bp_result: got %h ok=%b want %h", got, ok, want);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.x !== want.x || bus.x_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_hold: x=%h x_valid=%b in_ready=%b, want %h/1/0", bus.x,
                     bus.x_valid, bus.in_ready, want.x);
        end
        bus.in_valid = 1'b0;
        handshake();
        n_cmp++;
        if (bus.x_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: x_valid=%b in_ready=%b, want 0/1", bus.x_valid,
                     bus.in_ready);
        end
    endtask

    task automatic test_len_err();
        bit to, ok;
        exp_t got, want;
        vec_t av, wv;
        for (int i = 0; i < 8; i++) begin
            av[i] = 12'h100;
            wv[i] = 12'h080;
        end
        // Forced end at 8 beats without in_last.
        sb.push_back({12'h400, 1'b0, 1'b1});
        send_vec(av, wv, 12'h000, 8, 1'b0, to);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len_forced_stop: in_ready=%b want 0", bus.in_ready);
        end
        collect(ok, got, want);
        n_cmp++;
        if (to || !ok || got !== want) begin
            n_fail++;
            $display("FAIL len_forced: got %h ok=%b want %h", got, ok, want);
        end
        handshake();
        // in_last exactly on beat 8 is a normal end.
        sb.push_back({12'h400, 1'b0, 1'b0});
        send_vec(av, wv, 12'h000, 8, 1'b1, to);
        collect(ok, got, want);
        n_cmp++;
        if (to || !ok || got !== want) begin
            n_fail++;
            $display("FAIL len_exact: got %h ok=%b want %h", got, ok, want);
        end
        handshake();
    endtask

    task automatic test_mid_reset();
        bit to, ok;
        exp_t got, want;
        for (int i = 0; i < 3; i++) begin
            send_beat(12'h100, 12'h100, 12'h000, 1'b0, to);
        end
        idle_in();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.x_valid !== 1'b0 || bus.x !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_clear: x=%h x_valid=%b, want 000/0", bus.x, bus.x_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb.push_back({12'h100, 1'b0, 1'b0});
        send_beat(12'h100, 12'h100, 12'h000, 1'b1, to);
        idle_in();
        collect(ok, got, want);
        n_cmp++;
        if (to || !ok || got !== want) begin
            n_fail++;
            $display("FAIL midrst_next: got %h ok=%b want %h", got, ok, want);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit to, ok, forced;
        exp_t got, want;
        vec_t av, wv;
        int n;
        logic [11:0] b;
        for (int v = 0; v < 6; v++) begin
            n = $urandom_range(1, 8);
            b = 12'($urandom);
            for (int i = 0; i < 8; i++) begin
                av[i] = 12'($urandom);
                wv[i] = 12'($urandom);
            end
            forced = (n == 8) && ($urandom_range(0, 1) == 1);
            sb.push_back(model(b, av, wv, n, forced));
            send_vec(av, wv, b, n, !forced, to);
            collect(ok, got, want);
            n_cmp++;
            if (to || !ok || got !== want) begin
                n_fail++;
                $display("FAIL b2b_vec%0d: got %h ok=%b want %h", v, got, ok, want);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_vector("bias_only", 12'h000, 12'h000, 12'hF00, 1, {12'hF00, 1'b0, 1'b0});
        test_vector("sat_pos", 12'h700, 12'h700, 12'h000, 4, {12'h7FF, 1'b1, 1'b0});
        test_vector("sat_neg", 12'h700, 12'h900, 12'h000, 4, {12'h800, 1'b1, 1'b0});
`ifdef NEURON_MAC_ROUND_EN
        test_vector("round", 12'h001, 12'h080, 12'h000, 1, {12'h001, 1'b0, 1'b0});
`else
        test_vector("round", 12'h001, 12'h080, 12'h000, 1, {12'h000, 1'b0, 1'b0});
`endif
        test_backpressure();
        test_len_err();
        test_mid_reset();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d results left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
